servo_pwm_gen: RTL and testbench
================================

Name: servo_pwm_gen

Overview:
Generates the servo PWM waveform (`s_pulse`) that the servo output stage drives onto the `SERVO` pin. Keeps the active duty (`s_duty`, in clock cycles) and a target duty. Target is set by the `servo_flag` sweep commands or by a direct load. Active duty slews toward target by a fixed step once per PWM frame, so the servo never jumps; duty changes only at frame boundaries, so no glitched pulses.

Parameters:
PERIOD, 2000000, frame length in clk cycles (20 ms at 100 MHz)
DUTY_MIN, 100000, minimum pulse width in cycles (1.0 ms)
DUTY_MAX, 200000, maximum pulse width in cycles (2.0 ms)
DUTY_CENTER, 150000, centre pulse width; reset value (1.5 ms)
STEP, 1000, max duty change per frame in cycles
CW, 21, period counter width; must satisfy 2^CW >= PERIOD

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
servo_flag  in  3  [0] go to centre, [1] sweep to DUTY_MAX, [2] sweep to DUTY_MIN; level, sampled every cycle
duty_load  in  1  one-cycle strobe: load duty_in as target
duty_in  in  19  requested pulse width in cycles
s_pulse  out  1  PWM output to servo stage
s_duty  out  19  active pulse width for current frame
frame_start  out  1  one-cycle pulse on first cycle of each frame
busy  out  1  high while s_duty != target

Behaviour:
- One clock (`clk`). Reset is synchronous and active-high (`rst`), sampled on the clk rising edge. All state is registered.
- Reset values:
  - cnt = 0, target = DUTY_CENTER, s_duty = DUTY_CENTER
  - s_pulse = 0, frame_start = 0, busy = 0, state = HOLD
- Period counter cnt:
  - Increments each cycle; wraps from PERIOD-1 to 0.
  - First cycle after rst deasserts is cnt = 0.
- s_pulse (registered, 1-cycle latency): s_pulse <= (cnt < s_duty).
  - Exactly s_duty high cycles per frame, then PERIOD - s_duty low cycles.
  - Period is exactly PERIOD cycles.
- frame_start <= (cnt == 0); it coincides with the first high cycle of s_pulse.
- Target update, every cycle, priority high to low:
  1. duty_load: target <= clamp(duty_in, DUTY_MIN, DUTY_MAX)
  2. servo_flag[0]: target <= DUTY_CENTER
  3. servo_flag[1]: target <= DUTY_MAX
  4. servo_flag[2]: target <= DUTY_MIN
  5. otherwise target holds.
  - A target change mid-frame has no effect on the current pulse.
- FSM states: HOLD (s_duty == target), RISE (s_duty < target), FALL (s_duty > target).
  - State is re-evaluated combinationally from s_duty vs target every cycle, so a reversal mid-ramp goes directly RISE <-> FALL.
- Slew at frame end only (cnt == PERIOD-1):
  - RISE: s_duty <= min(s_duty + STEP, target)
  - FALL: s_duty <= max(s_duty - STEP, target)
  - HOLD: s_duty unchanged.
  - New s_duty takes effect from cnt = 0 of the next frame.
- Arithmetic:
  - Comparisons and the +STEP sum are done at 20 bits, so s_duty never wraps.
  - Result always lies in [DUTY_MIN, DUTY_MAX].
- busy = (state != HOLD), registered alongside the state.
- Reset mid-frame or mid-ramp: all state returns to reset values on the next edge; the pulse in progress is truncated (s_pulse = 0).
- If target changes in the same cycle as the frame-end slew, the slew uses the old target; the new target applies from the next frame end.

Test Plan:
Scenario 1, reset/centre. Sim params PERIOD=100, MIN=10, MAX=20, CENTER=15, STEP=2. Hold rst 3 cycles, release, no inputs → s_pulse high exactly 15 of every 100 cycles; frame_start every 100 cycles, aligned with the s_pulse rising edge; busy=0.

Scenario 2, sweep up. Assert servo_flag=3'b010 from idle → s_duty reads 17, 19, 20 at successive frame starts, then holds at 20. busy falls when s_duty reaches 20.

Scenario 3, priority and clamp. In one cycle pulse duty_load with duty_in=5 and servo_flag=3'b011 → target=10 (load wins, clamped). s_duty goes 13, 11, 10. Then duty_load with duty_in=500 → target=20.

Scenario 4, mid-ramp reversal. During the up-sweep at s_duty=17, switch servo_flag to 3'b100 → next frame s_duty=15, then 13, 11, 10. No frame has a pulse width outside [10, 20].

Scenario 5, mid-frame load. duty_load with duty_in=12 at cnt=5 (s_duty=15) → current frame still has 15 high cycles; the next frame has 13.

Scenario 6, reset mid-pulse. Assert rst at cnt=7 during a ramp → s_pulse=0 the next cycle. After release, s_duty=15, busy=0, and frame timing restarts at cnt=0.

Source files
------------

// File: rtl/servo_pwm_gen.sv
// Servo PWM generator: fixed-length frames, pulse width slewed toward a
// target by at most STEP cycles per frame, applied only at frame boundaries.
module servo_pwm_gen #(
  parameter int unsigned PERIOD      = 2000000,
  parameter int unsigned DUTY_MIN    = 100000,
  parameter int unsigned DUTY_MAX    = 200000,
  parameter int unsigned DUTY_CENTER = 150000,
  parameter int unsigned STEP        = 1000,
  parameter int unsigned CW          = 21
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  servo_flag,
  input  logic        duty_load,
  input  logic [18:0] duty_in,
  output logic        s_pulse,
  output logic [18:0] s_duty,
  output logic        frame_start,
  output logic        busy
);

  typedef enum logic [1:0] {HOLD, RISE, FALL} state_t;

  // Width used when comparing the period counter against the duty.
  localparam int unsigned XW = (CW > 20) ? CW : 20;

  localparam logic [18:0] D_MIN    = 19'(DUTY_MIN);
  localparam logic [18:0] D_MAX    = 19'(DUTY_MAX);
  localparam logic [18:0] D_CENTER = 19'(DUTY_CENTER);
  localparam logic [18:0] D_STEP   = 19'(STEP);
  localparam logic [19:0] W_MIN    = 20'(DUTY_MIN);
  localparam logic [19:0] W_MAX    = 20'(DUTY_MAX);
  localparam logic [19:0] W_STEP   = 20'(STEP);
  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt;
  logic [18:0]   target;
  logic [18:0]   target_nx;
  logic [18:0]   duty_nx;
  logic [18:0]   load_val;
  logic [19:0]   duty_w;
  logic [19:0]   tgt_w;
  logic [19:0]   in_w;
  logic [19:0]   sum_w;
  logic          frame_end;
  state_t        state;
  state_t        state_nx;

  // All duty arithmetic is done one bit wider so the +STEP sum cannot wrap.
  assign duty_w    = {1'b0, s_duty};
  assign tgt_w     = {1'b0, target};
  assign in_w      = {1'b0, duty_in};
  assign sum_w     = duty_w + W_STEP;
  assign frame_end = (cnt == CNT_LAST);
  assign busy      = (state != HOLD);

  // Direction of travel derived directly from the live duty/target pair.
  always_comb begin
    state_nx = HOLD;
    if (duty_w < tgt_w) begin
      state_nx = RISE;
    end else if (duty_w > tgt_w) begin
      state_nx = FALL;
    end
  end

  // Slewed duty candidate: one STEP toward target, never overshooting it.
  // The FALL test is rearranged as duty < target + STEP to avoid an underflow.
  always_comb begin
    duty_nx = s_duty;
    case (state_nx)
      RISE:    duty_nx = (sum_w > tgt_w) ? target : sum_w[18:0];
      FALL:    duty_nx = (duty_w < (tgt_w + W_STEP)) ? target : (s_duty - D_STEP);
      default: duty_nx = s_duty;
    endcase
  end

  // Target selection: load (clamped) beats centre beats max beats min.
  always_comb begin
    load_val = duty_in;
    if (in_w < W_MIN) begin
      load_val = D_MIN;
    end else if (in_w > W_MAX) begin
      load_val = D_MAX;
    end
    target_nx = target;
    if (duty_load) begin
      target_nx = load_val;
    end else if (servo_flag[0]) begin
      target_nx = D_CENTER;
    end else if (servo_flag[1]) begin
      target_nx = D_MAX;
    end else if (servo_flag[2]) begin
      target_nx = D_MIN;
    end
  end

  // Frame counter, pulse output, target register, and frame-end duty update.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      target      <= D_CENTER;
      s_duty      <= D_CENTER;
      s_pulse     <= 1'b0;
      frame_start <= 1'b0;
      state       <= HOLD;
    end else begin
      cnt         <= frame_end ? '0 : cnt + CW'(1);
      s_pulse     <= (XW'(cnt) < XW'(s_duty));
      frame_start <= (cnt == '0);
      target      <= target_nx;
      state       <= state_nx;
      if (frame_end) begin
        s_duty <= duty_nx;
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Self-checking bench for servo_pwm_gen with a cycle-level behavioural model.
module tb_servo_pwm_gen;

  localparam int P  = 100;
  localparam int MN = 10;
  localparam int MX = 20;
  localparam int C  = 15;
  localparam int S  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  servo_flag;
  logic        duty_load;
  logic [18:0] duty_in;
  logic        s_pulse;
  logic [18:0] s_duty;
  logic        frame_start;
  logic        busy;

  servo_pwm_gen #(
    .PERIOD(P),
    .DUTY_MIN(MN),
    .DUTY_MAX(MX),
    .DUTY_CENTER(C),
    .STEP(S),
    .CW(7)
  ) dut (
    .clk(clk),
    .rst(rst),
    .servo_flag(servo_flag),
    .duty_load(duty_load),
    .duty_in(duty_in),
    .s_pulse(s_pulse),
    .s_duty(s_duty),
    .frame_start(frame_start),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state: position in frame, target, active duty, outputs.
  int m_ph = 0;
  int m_tgt = C;
  int m_duty = C;
  int m_pulse = 0;
  int m_fs = 0;
  int m_busy = 0;
  int wcnt = 0;
  int last_width = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clampf(input int v);
    if (v < MN) return MN;
    if (v > MX) return MX;
    return v;
  endfunction

  // One clock: advance the model on the edge using the driven inputs, then compare.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      m_ph = 0; m_tgt = C; m_duty = C;
      m_pulse = 0; m_fs = 0; m_busy = 0;
    end else begin
      m_busy  = (m_duty != m_tgt) ? 1 : 0;
      m_pulse = (m_ph < m_duty) ? 1 : 0;
      m_fs    = (m_ph == 0) ? 1 : 0;
      if (m_ph == P - 1) begin
        if (m_duty < m_tgt)      m_duty = (m_duty + S > m_tgt) ? m_tgt : m_duty + S;
        else if (m_duty > m_tgt) m_duty = (m_duty - S < m_tgt) ? m_tgt : m_duty - S;
      end
      if (duty_load)          m_tgt = clampf(int'(duty_in));
      else if (servo_flag[0]) m_tgt = C;
      else if (servo_flag[1]) m_tgt = MX;
      else if (servo_flag[2]) m_tgt = MN;
      m_ph = (m_ph + 1) % P;
    end
    #1;
    check("pulse", 32'(s_pulse), 32'(m_pulse));
    check("frame_start", 32'(frame_start), 32'(m_fs));
    check("duty", 32'(s_duty), 32'(m_duty));
    check("busy", 32'(busy), 32'(m_busy));
    if (frame_start) begin
      last_width = wcnt;
      wcnt = 0;
    end
    if (s_pulse) wcnt++;
  endtask

  // Advance until the next frame_start, bounded to two frames.
  task automatic run_to_frame(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!frame_start && n < 2 * P);
    check("frame_wait", 32'(frame_start), 32'd1);
  endtask

  initial begin
    int n;
    int exp_dn[5] = '{18, 16, 14, 12, 10};
    rst = 1'b1; servo_flag = '0; duty_load = 1'b0; duty_in = '0;

    // Reset and idle at centre
    repeat (3) step();
    check("rst_duty", 32'(s_duty), 32'd15);
    check("rst_pulse", 32'(s_pulse), 32'd0);
    rst = 1'b0;
    run_to_frame(n);
    check("first_frame_latency", 32'(n), 32'd1);
    for (int i = 0; i < 3; i++) begin
      run_to_frame(n);
      check("s1_period", 32'(n), 32'(P));
      check("s1_width", 32'(last_width), 32'd15);
      check("s1_busy", 32'(busy), 32'd0);
    end

    // Sweep up to max
    servo_flag = 3'b010;
    run_to_frame(n); check("s2_d17", 32'(s_duty), 32'd17); check("s2_busy", 32'(busy), 32'd1);
    run_to_frame(n); check("s2_d19", 32'(s_duty), 32'd19); check("s2_busy", 32'(busy), 32'd1);
    run_to_frame(n); check("s2_d20", 32'(s_duty), 32'd20); check("s2_idle", 32'(busy), 32'd0);
    run_to_frame(n); check("s2_hold", 32'(s_duty), 32'd20); check("s2_w20", 32'(last_width), 32'd20);
    servo_flag = '0;

    // Load beats flags and is clamped low; then clamped high
    duty_load = 1'b1; duty_in = 19'd5; servo_flag = 3'b011;
    step();
    duty_load = 1'b0; servo_flag = '0;
    for (int i = 0; i < 5; i++) begin
      run_to_frame(n);
      check("s3_down", 32'(s_duty), 32'(exp_dn[i]));
    end
    check("s3_idle", 32'(busy), 32'd0);
    duty_load = 1'b1; duty_in = 19'd500;
    step();
    duty_load = 1'b0;
    run_to_frame(n); check("s3_up12", 32'(s_duty), 32'd12); check("s3_busy", 32'(busy), 32'd1);
    run_to_frame(n); check("s3_up14", 32'(s_duty), 32'd14);
    run_to_frame(n); check("s3_up16", 32'(s_duty), 32'd16);

    // Reversal mid-ramp goes straight to falling
    servo_flag = 3'b100;
    run_to_frame(n); check("s4_d14", 32'(s_duty), 32'd14);
    check("s4_range", 32'((last_width >= MN) && (last_width <= MX)), 32'd1);
    run_to_frame(n); check("s4_d12", 32'(s_duty), 32'd12);
    run_to_frame(n); check("s4_d10", 32'(s_duty), 32'd10);
    run_to_frame(n); check("s4_hold", 32'(s_duty), 32'd10); check("s4_idle", 32'(busy), 32'd0);
    servo_flag = '0;

    // Mid-frame load leaves the current pulse untouched
    servo_flag = 3'b001;
    run_to_frame(n); check("s5_d12", 32'(s_duty), 32'd12);
    run_to_frame(n); check("s5_d14", 32'(s_duty), 32'd14);
    run_to_frame(n); check("s5_d15", 32'(s_duty), 32'd15);
    servo_flag = '0;
    while (m_ph != 5) step();
    duty_load = 1'b1; duty_in = 19'd12;
    step();
    duty_load = 1'b0;
    run_to_frame(n); check("s5_d13", 32'(s_duty), 32'd13); check("s5_w15", 32'(last_width), 32'd15);
    run_to_frame(n); check("s5_d12b", 32'(s_duty), 32'd12); check("s5_w13", 32'(last_width), 32'd13);

    // Reset mid-pulse during a ramp
    servo_flag = 3'b010;
    run_to_frame(n); check("s6_d14", 32'(s_duty), 32'd14);
    while (m_ph != 7) step();
    rst = 1'b1;
    step();
    check("s6_pulse0", 32'(s_pulse), 32'd0);
    check("s6_duty", 32'(s_duty), 32'd15);
    check("s6_busy", 32'(busy), 32'd0);
    rst = 1'b0; servo_flag = '0;
    run_to_frame(n); check("s6_restart", 32'(n), 32'd1);
    run_to_frame(n); check("s6_w15", 32'(last_width), 32'd15);

    // Randomised flags and loads against the model
    for (int i = 0; i < 30 * P; i++) begin
      if ($urandom_range(0, 39) == 0) servo_flag = 3'($urandom_range(0, 7));
      duty_load = ($urandom_range(0, 59) == 0);
      duty_in = ($urandom_range(0, 3) == 0) ? 19'($urandom_range(0, 524287)) : 19'($urandom_range(0, 30));
      step();
      if (frame_start) check("rand_range", 32'((s_duty >= MN) && (s_duty <= MX)), 32'd1);
    end
    duty_load = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
